// File: rtl/asmd_job_scheduler.sv
// Round-robin job scheduler sharing one ASMD counter datapath/controller among NREQ requesters.
// Optional RUN-state watchdog is compiled in with `define SCHED_WATCHDOG_EN.
module asmd_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] ack_o,
  output logic [IDW-1:0]  grant_id_o,
  output logic            busy_o,
  output logic            result_e_o,
  output logic            dp_start_o,
  input  logic            dp_f_i,
  input  logic            dp_e_i,
  output logic            err_timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  state_t          state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            result_q, result_d;
  logic            first_q, first_d;
  logic            win_found_s;
  logic [IDW-1:0]  win_idx_s;
  logic [IDW-1:0]  cand_s;

`ifdef SCHED_WATCHDOG_EN
  logic [7:0]      cnt_q, cnt_d;
  logic            to_q, to_d;
`endif

  // Rotating-priority search: first set request after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!win_found_s && req_i[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and register updates for the job lifecycle.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    result_d = result_q;
    first_d  = first_q;
`ifdef SCHED_WATCHDOG_EN
    cnt_d    = cnt_q;
    to_d     = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          grant_d  = win_idx_s;
          rr_ptr_d = win_idx_s;
          state_d  = START;
        end else begin
          state_d  = IDLE;
        end
      end
      START: begin
        first_d = 1'b1;
`ifdef SCHED_WATCHDOG_EN
        cnt_d   = 8'd0;
        to_d    = 1'b0;
`endif
        state_d = RUN;
      end
      RUN: begin
        first_d = 1'b0;
`ifdef SCHED_WATCHDOG_EN
        cnt_d   = (cnt_q == 8'd255) ? cnt_q : cnt_q + 8'd1;
`endif
        // F in the first RUN cycle may be left over from the previous job.
        if (!first_q && dp_f_i) begin
          result_d = dp_e_i;
          state_d  = DONE;
        end
`ifdef SCHED_WATCHDOG_EN
        else if (cnt_d >= 8'(TIMEOUT)) begin
          result_d = 1'b0;
          to_d     = 1'b1;
          state_d  = DONE;
        end
`endif
        else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and job registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IDW'(NREQ - 1);
      result_q <= 1'b0;
      first_q  <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      cnt_q    <= 8'd0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      result_q <= result_d;
      first_q  <= first_d;
`ifdef SCHED_WATCHDOG_EN
      cnt_q    <= cnt_d;
      to_q     <= to_d;
`endif
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign dp_start_o = (state_q == START);
  assign ack_o      = (state_q == DONE) ? (ONE_HOT0 << grant_q) : '0;
  assign grant_id_o = grant_q;
  assign result_e_o = result_q;

`ifdef SCHED_WATCHDOG_EN
  assign err_timeout_o = (state_q == DONE) && to_q;
`else
  assign err_timeout_o = 1'b0 & (TIMEOUT > 255);
`endif

endmodule

// File: tb/tb_asmd_job_scheduler.sv
// Self-checking bench for asmd_job_scheduler: job-level reference model plus an emulated datapath.
module tb_asmd_job_scheduler;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 31;
  localparam int IDW     = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req   = '0;
  logic            dp_F  = 1'b0;
  logic            dp_E  = 1'b0;
  logic [NREQ-1:0] ack_o;
  logic [IDW-1:0]  grant_id_o;
  logic            busy_o, result_e_o, dp_start_o, err_timeout_o;

  asmd_job_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .req_i         (req),
    .ack_o         (ack_o),
    .grant_id_o    (grant_id_o),
    .busy_o        (busy_o),
    .result_e_o    (result_e_o),
    .dp_start_o    (dp_start_o),
    .dp_f_i        (dp_F),
    .dp_e_i        (dp_E),
    .err_timeout_o (err_timeout_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Job-level model: a job is described by its owner and the cycle numbers of START and DONE.
  int cyc = 0;
  bit m_job, m_res, m_err;
  int m_owner, m_ptr, m_start_c, m_done_c;

  // Emulated datapath: F rises dp_lat cycles into the job and stays high until the next Start.
  bit dp_on;
  int dp_cnt, dp_lat, next_lat;
  bit rand_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 1; k <= NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ack();
    logic [NREQ-1:0] v;
    v = '0;
    if (m_job && cyc == m_done_c) v[m_owner] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_job = 1'b0; m_owner = 0; m_ptr = NREQ - 1; m_res = 1'b0; m_err = 1'b0;
    m_start_c = -10; m_done_c = -1;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic f, input logic e);
    int c;
    c = cyc;
    if (!m_job) begin
      if (r != '0) begin
        m_owner = pick(r, m_ptr); m_ptr = m_owner; m_job = 1'b1;
        m_start_c = c + 1; m_done_c = -1; m_err = 1'b0;
      end
    end else if (c == m_done_c) begin
      m_job = 1'b0;
    end else if (m_done_c < 0 && c >= m_start_c + 2 && f) begin
      m_done_c = c + 1; m_res = e;
    end
`ifdef SCHED_WATCHDOG_EN
    else if (m_done_c < 0 && c - m_start_c >= TIMEOUT) begin
      m_done_c = c + 1; m_res = 1'b0; m_err = 1'b1;
    end
`endif
  endtask

  task automatic tick();
    logic s_start, s_F, s_E, s_rst;
    logic [NREQ-1:0] s_req;
    s_start = dp_start_o; s_req = req; s_F = dp_F; s_E = dp_E; s_rst = reset;
    @(posedge clock); #1;
    if (s_rst) begin
      model_reset(); dp_on = 1'b0; dp_F = 1'b0;
    end else begin
      model_step(s_req, s_F, s_E);
      if (s_start) begin dp_on = 1'b1; dp_cnt = 1; dp_lat = next_lat; end
      else if (dp_on) dp_cnt++;
      dp_F = dp_on && (dp_cnt >= dp_lat);
      dp_E = rand_e ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; model_reset(); dp_on = 1'b0; dp_F = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_ack(output int n, input int budget);
    n = 0;
    do begin tick(); n++; end while (ack_o == '0 && n < budget);
    if (ack_o == '0) begin
      checks++; errors++;
      $display("FAIL wait_ack: no ack within %0d cycles", budget);
    end
  endtask

  task automatic wait_start(output int n, input int budget);
    n = 0;
    do begin tick(); n++; end while (!dp_start_o && n < budget);
  endtask

  function automatic int ack_idx(input logic [NREQ-1:0] a);
    for (int i = 0; i < NREQ; i++) if (a[i]) return i;
    return -1;
  endfunction

  // Cycle-by-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      chk("busy", busy_o, m_job);
      chk("dp_start", dp_start_o, m_job && cyc == m_start_c);
      chk("ack", ack_o, exp_ack());
      chk("grant_id", grant_id_o, m_owner);
      chk("result_E", result_e_o, m_res);
      chk("err_timeout", err_timeout_o, m_job && cyc == m_done_c && m_err);
    end
  end

  initial begin
    int n;
    int got[4];
    int want[4];
    want = '{0, 1, 3, 0};

    chk("pick_a", pick(4'b1011, 3), 0);
    chk("pick_b", pick(4'b1011, 0), 1);
    chk("pick_c", pick(4'b1011, 1), 3);
    chk("pick_d", pick(4'b0100, 2), 2);

    next_lat = 14; rand_e = 1'b0;
    do_reset();
    chk_en = 1'b1;
    chk("rst_busy", busy_o, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_grant", grant_id_o, 0);
    chk("rst_start", dp_start_o, 0);

    // First job: fixed 14-cycle datapath gives ack 15 cycles after Start.
    req = 4'b0001;
    tick();
    chk("t1_start", dp_start_o, 1);
    wait_ack(n, 40);
    chk("t1_latency", n, 15);
    chk("t1_ack", ack_o, 4'b0001);
    chk("t1_result", result_e_o, 1);
    chk("t1_grant", grant_id_o, 0);
    req = 4'b0000;
    tick();

    // Contention with requests held.
    do_reset();
    req = 4'b1011;
    for (int j = 0; j < 4; j++) begin
      wait_ack(n, 60);
      got[j] = ack_idx(ack_o);
    end
    req = 4'b0000;
    for (int j = 0; j < 4; j++) chk("contention_order", got[j], want[j]);
    tick();

    // Late request during RUN waits for DONE plus one idle cycle.
    do_reset();
    req = 4'b0001;
    repeat (3) tick();
    req = 4'b0101;
    wait_ack(n, 40);
    chk("late_ack0", ack_o, 4'b0001);
    req = 4'b0100;
    wait_start(n, 10);
    chk("late_gap", n, 2);
    chk("late_grant", grant_id_o, 2);
    wait_ack(n, 40);
    chk("late_ack2", ack_o, 4'b0100);
    req = 4'b0000;
    tick();

    // Withdrawn request still completes; pointer moves to 1.
    do_reset();
    req = 4'b0010;
    repeat (4) tick();
    req = 4'b0000;
    wait_ack(n, 40);
    chk("wd_ack1", ack_o, 4'b0010);
    tick();
    req = 4'b1001;
    wait_start(n, 10);
    chk("ptr_after_withdraw", grant_id_o, 3);
    wait_ack(n, 40);
    req = 4'b0000;
    tick();

    // Asynchronous reset in the middle of RUN.
    do_reset();
    req = 4'b0001;
    repeat (5) tick();
    #2;
    reset = 1'b1; model_reset(); dp_on = 1'b0; dp_F = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ack", ack_o, 0);
    chk("mid_rst_start", dp_start_o, 0);
    chk("mid_rst_grant", grant_id_o, 0);
    req = 4'b0000;
    tick();
    reset = 1'b0;
    tick();
    req = 4'b0001;
    wait_ack(n, 40);
    chk("post_rst_ack", ack_o, 4'b0001);
    req = 4'b0000;
    tick();

    // Randomized traffic with random datapath latency and E.
    rand_e = 1'b1;
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      next_lat = $urandom_range(1, 20);
      for (int i = 0; i < NREQ; i++) begin
        if (ack_o[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 31) == 0) req[i] = 1'b0;
      end
      tick();
    end
    req = 4'b0000;
    repeat (40) tick();

    // Datapath that never raises F.
    rand_e = 1'b0; next_lat = 100000;
    do_reset();
    req = 4'b0001;
    tick();
    chk("stuck_start", dp_start_o, 1);
`ifdef SCHED_WATCHDOG_EN
    wait_ack(n, 60);
    chk("wdog_latency", n, 32);
    chk("wdog_ack", ack_o, 4'b0001);
    chk("wdog_err", err_timeout_o, 1);
    chk("wdog_result", result_e_o, 0);
    req = 4'b0000;
    tick();
`else
    n = 0;
    repeat (200) begin
      tick();
      if (ack_o != '0) n++;
    end
    chk("no_wdog_acks", n, 0);
    chk("no_wdog_busy", busy_o, 1);
    req = 4'b0000;
`endif
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
